// File: rtl/alarm_set_ctrl.sv
// Mode/set sequencer for the alarm clock: stages hour/minute edits and commits
// them to the time and alarm registers through one-cycle enable strobes.
module alarm_set_ctrl #(
  parameter int unsigned TIMEOUT = 10
) (
  input  logic       Clock,
  input  logic       Clear,
  input  logic       Mode,
  input  logic       Inc,
  input  logic       Tick,
  input  logic [4:0] Cur_hr,
  input  logic [5:0] Cur_min,
  input  logic [4:0] Alm_hr,
  input  logic [5:0] Alm_min,
  output logic [4:0] D_hr,
  output logic [5:0] D_min,
  output logic       En_t_hr,
  output logic       En_t_min,
  output logic       En_a_hr,
  output logic       En_a_min,
  output logic [2:0] Set_state,
  output logic       Blink
);

  typedef enum logic [2:0] {
    RUN       = 3'd0,
    SET_T_HR  = 3'd1,
    SET_T_MIN = 3'd2,
    LOAD_A    = 3'd3,
    SET_A_HR  = 3'd4,
    SET_A_MIN = 3'd5
  } state_t;

  localparam int unsigned IW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [IW-1:0] IDLE_LAST = IW'(TIMEOUT - 1);

  state_t        state_q;
  logic [4:0]    d_hr_q;
  logic [5:0]    d_min_q;
  logic          en_t_hr_q, en_t_min_q, en_a_hr_q, en_a_min_q;
  logic          blink_q;
  logic [IW-1:0] idle_q;

  logic [4:0]    hr_inc_d;
  logic [5:0]    min_inc_d;

  // >= rather than == so out-of-range staging values also wrap to 0
  always_comb begin
    hr_inc_d  = (d_hr_q  >= 5'd23) ? '0 : d_hr_q + 5'd1;
    min_inc_d = (d_min_q >= 6'd59) ? '0 : d_min_q + 6'd1;
  end

  always_ff @(posedge Clock or negedge Clear) begin
    if (!Clear) begin
      state_q    <= RUN;
      d_hr_q     <= '0;
      d_min_q    <= '0;
      en_t_hr_q  <= 1'b0;
      en_t_min_q <= 1'b0;
      en_a_hr_q  <= 1'b0;
      en_a_min_q <= 1'b0;
      blink_q    <= 1'b0;
      idle_q     <= '0;
    end else begin
      en_t_hr_q  <= 1'b0;
      en_t_min_q <= 1'b0;
      en_a_hr_q  <= 1'b0;
      en_a_min_q <= 1'b0;
      case (state_q)
        RUN: begin
          blink_q <= 1'b0;
          idle_q  <= '0;
          if (Mode) begin
            d_hr_q  <= Cur_hr;
            d_min_q <= Cur_min;
            state_q <= SET_T_HR;
          end
        end
        LOAD_A: begin
          if (Tick) blink_q <= ~blink_q;
          d_hr_q  <= Alm_hr;
          d_min_q <= Alm_min;
          state_q <= SET_A_HR;
        end
        SET_T_HR, SET_T_MIN, SET_A_HR, SET_A_MIN: begin
          if (Tick) blink_q <= ~blink_q;
          if (Mode) begin
            idle_q <= '0;
            case (state_q)
              SET_T_HR:  begin en_t_hr_q  <= 1'b1; state_q <= SET_T_MIN; end
              SET_T_MIN: begin en_t_min_q <= 1'b1; state_q <= LOAD_A;    end
              SET_A_HR:  begin en_a_hr_q  <= 1'b1; state_q <= SET_A_MIN; end
              default:   begin en_a_min_q <= 1'b1; state_q <= RUN; blink_q <= 1'b0; end
            endcase
          end else if (Inc) begin
            idle_q <= '0;
            if (state_q == SET_T_HR || state_q == SET_A_HR) d_hr_q <= hr_inc_d;
            else                                            d_min_q <= min_inc_d;
          end else if (Tick) begin
            if (idle_q >= IDLE_LAST) begin
              state_q <= RUN;
              idle_q  <= '0;
              blink_q <= 1'b0;
            end else begin
              idle_q <= idle_q + 1'b1;
            end
          end
        end
        default: begin
          state_q <= RUN;
          blink_q <= 1'b0;
          idle_q  <= '0;
        end
      endcase
    end
  end

  assign D_hr      = d_hr_q;
  assign D_min     = d_min_q;
  assign En_t_hr   = en_t_hr_q;
  assign En_t_min  = en_t_min_q;
  assign En_a_hr   = en_a_hr_q;
  assign En_a_min  = en_a_min_q;
  assign Set_state = state_q;
  assign Blink     = blink_q;

endmodule

// File: doc/alarm_set_ctrl.md
# alarm_set_ctrl

Mode/set sequencer for the alarm clock. It owns a staging value that the user edits with two buttons, Mode and Inc, and writes that value into the external time-of-day and alarm hour/minute registers through one-cycle enable strobes. It sits between the debounced button logic and the register bank; the registers' D inputs are driven from D_hr/D_min and their Enable inputs from the En_* strobes.

## Interface
- TIMEOUT, default 10: number of Tick strobes with no button press after which an edit session aborts to RUN.
- Clock  in  1  system clock; all state changes on its rising edge.
- Clear  in  1  asynchronous, active-low reset.
- Mode  in  1  single-cycle pulse, already synchronized and debounced; advances the edit field.
- Inc  in  1  single-cycle pulse, already synchronized and debounced; increments the field being edited.
- Tick  in  1  one-cycle 1 Hz strobe.
- Cur_hr / Cur_min  in  5 / 6  current time-register values, binary.
- Alm_hr / Alm_min  in  5 / 6  current alarm-register values, binary.
- D_hr / D_min  out  5 / 6  staging values; feed the register D inputs.
- En_t_hr, En_t_min, En_a_hr, En_a_min  out  1 each  one-cycle write strobes.
- Set_state  out  3  state code.
- Blink  out  1  display blink phase.

## Operation
- States and Set_state codes: RUN=0, SET_T_HR=1, SET_T_MIN=2, LOAD_A=3, SET_A_HR=4, SET_A_MIN=5. Codes 6 and 7 go to RUN on the next edge.
- RUN, on Mode: load D_hr←Cur_hr and D_min←Cur_min, then go to SET_T_HR. Inc is ignored in RUN.
- SET_T_HR:
  - Inc: D_hr←(D_hr==23)?0:D_hr+1.
  - Mode: go to SET_T_MIN with En_t_hr=1.
- SET_T_MIN:
  - Inc: D_min←(D_min==59)?0:D_min+1.
  - Mode: go to LOAD_A with En_t_min=1.
- LOAD_A: lasts one cycle. Load D_hr←Alm_hr and D_min←Alm_min, then go to SET_A_HR. Mode and Inc are ignored.
- SET_A_HR: Inc wraps hours as above; Mode goes to SET_A_MIN with En_a_hr=1.
- SET_A_MIN: Inc wraps minutes as above; Mode goes to RUN with En_a_min=1.
- Staging values held by inputs out of range (hr>23, min>59) wrap to 0 on the next Inc.
- Mode and Inc in the same cycle: Mode wins and Inc is dropped.
- Idle counter:
  - Cleared on any Mode or Inc, and on entry to RUN.
  - In set states (1, 2, 4, 5) it increments on each Tick that arrives without a button press in the same cycle.
  - When the count reaches TIMEOUT: go to RUN with no strobe. Fields already committed stay written; the field being edited is discarded.
- Blink: 0 in RUN. In states 1–5 it toggles on each Tick and is 0 on entry from RUN.

## Timing
- All outputs are registered. Reset values: Set_state=0, D_hr=0, D_min=0, all En_*=0, Blink=0, idle counter 0.
- Each En_* is high for exactly the one cycle after the edge that sampled Mode.
- During a strobe cycle, D_hr/D_min keep the committed value; the staging reload happens at the following edge (this is why LOAD_A exists).
- An Inc takes effect on D_* one cycle after it is sampled.
- Clear asserted mid-session drops to the reset values immediately, with no strobe.
- A timeout that coincides with Mode: Mode wins, the counter clears and the strobe fires.

## Test plan
- Reset mid-edit: Clear=0 while in state 2 with D_min=17 → all outputs at reset values in the same cycle, with no En_* pulse.
- Full session:
  - Stimulus: Cur=10:30, Alm=06:00, then Mode, Inc×2, Mode, Inc, Mode, Mode, Inc×3, Mode.
  - Required strobes: En_t_hr with D_hr=12, En_t_min with D_min=31, En_a_hr with D_hr=6, En_a_min with D_min=3.
  - Each strobe is exactly one cycle wide; the session ends with Set_state=0.
- Wrap-around:
  - Cur_hr=22, Inc×3 in SET_T_HR → D_hr sequence 23, 0, 1.
  - Cur_min=58, Inc×2 in SET_T_MIN → D_min sequence 59, 0.
- Timeout with TIMEOUT=3:
  - In SET_A_HR, 3 Ticks with no press → Set_state=0, En_a_hr is never asserted, Blink=0.
  - In the same setup, an Inc on the 2nd Tick cycle restarts the count, so the timeout fires on the 5th Tick.
- Simultaneous Mode+Inc in SET_T_HR with D_hr=5 → En_t_hr with D_hr=5 (no increment), and the next state is 2.
- LOAD_A ignore: Mode pulse in the LOAD_A cycle → state goes 3→4 only, and En_a_hr is not asserted.
